// File: rtl/md_pkg.sv
// ============================================================================
// Module : md_pkg
// Brief  : Shared op codes, FSM encoding and helpers for the MD unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package md_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MADD  = 4'd5;
    localparam logic [3:0] MD_MADDU = 4'd6;
    localparam logic [3:0] MD_MSUB  = 4'd7;
    localparam logic [3:0] MD_MSUBU = 4'd8;
    localparam logic [3:0] MD_MTHI  = 4'd9;
    localparam logic [3:0] MD_MTLO  = 4'd10;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic int md_cnt_width(input int mult_lat, input int div_lat);
        int m;
        m = (mult_lat > div_lat) ? mult_lat : div_lat;
        return $clog2(m + 1);
    endfunction

    // Ops that occupy the unit for a multi-cycle run (MULT..MSUBU)
    function automatic logic md_is_long(input logic [3:0] op);
        return (op >= MD_MULT) && (op <= MD_MSUBU);
    endfunction

    function automatic logic md_is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/md_datapath.sv
// ============================================================================
// Module : md_datapath
// Brief  : Combinational multiply/divide/accumulate producing next HI/LO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module md_datapath
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    output logic [WIDTH-1:0] o_next_hi,
    output logic [WIDTH-1:0] o_next_lo
);

    localparam int C_W2 = 2 * WIDTH;

    logic [C_W2-1:0]  w_sa, w_sb, w_ua, w_ub;
    logic [C_W2-1:0]  w_prod_s, w_prod_u, w_acc;
    logic [WIDTH-1:0] w_min, w_b_safe;
    logic             w_bzero, w_ovf;
    logic [WIDTH-1:0] w_sq, w_sr, w_uq, w_ur;

    // Products of 2*WIDTH-extended operands are exact modulo 2^(2*WIDTH)
    assign w_sa     = {{WIDTH{i_a[WIDTH-1]}}, i_a};
    assign w_sb     = {{WIDTH{i_b[WIDTH-1]}}, i_b};
    assign w_ua     = {{WIDTH{1'b0}}, i_a};
    assign w_ub     = {{WIDTH{1'b0}}, i_b};
    assign w_prod_s = w_sa * w_sb;
    assign w_prod_u = w_ua * w_ub;
    assign w_acc    = {i_hi, i_lo};

    assign w_min    = {1'b1, {(WIDTH-1){1'b0}}};
    assign w_bzero  = (i_b == '0);
    assign w_ovf    = (i_a == w_min) && (i_b == {WIDTH{1'b1}});
    // Keep the divider away from the divide-by-zero and overflow corners
    assign w_b_safe = (w_bzero || w_ovf) ? {{(WIDTH-1){1'b0}}, 1'b1} : i_b;

    assign w_sq = $signed(i_a) / $signed(w_b_safe);
    assign w_sr = $signed(i_a) % $signed(w_b_safe);
    assign w_uq = i_a / w_b_safe;
    assign w_ur = i_a % w_b_safe;

    always_comb begin
        o_next_hi = i_hi;
        o_next_lo = i_lo;
        case (i_op)
            MD_MULT:  {o_next_hi, o_next_lo} = w_prod_s;
            MD_MULTU: {o_next_hi, o_next_lo} = w_prod_u;
            MD_MADD:  {o_next_hi, o_next_lo} = w_acc + w_prod_s;
            MD_MADDU: {o_next_hi, o_next_lo} = w_acc + w_prod_u;
            MD_MSUB:  {o_next_hi, o_next_lo} = w_acc - w_prod_s;
            MD_MSUBU: {o_next_hi, o_next_lo} = w_acc - w_prod_u;
            MD_DIV: begin
                if (w_ovf) begin
                    o_next_hi = '0;
                    o_next_lo = w_min;
                end else if (!w_bzero) begin
                    o_next_hi = w_sr;
                    o_next_lo = w_sq;
                end
            end
            MD_DIVU: begin
                if (!w_bzero) begin
                    o_next_hi = w_ur;
                    o_next_lo = w_uq;
                end
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/md_unit_param.sv
// ============================================================================
// Module : md_unit_param
// Brief  : Parametrised multi-cycle MD unit with HI/LO, flush and MAC ops.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module md_unit_param
    import md_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       md_op,
    input  logic             flush,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int                   C_CNT_W    = md_cnt_width(MULT_LAT, DIV_LAT);
    localparam logic [C_CNT_W-1:0]   C_MULT_CNT = C_CNT_W'(MULT_LAT);
    localparam logic [C_CNT_W-1:0]   C_DIV_CNT  = C_CNT_W'(DIV_LAT);
    localparam logic [C_CNT_W-1:0]   C_ONE      = C_CNT_W'(1);

    logic [0:0]         r_state;
    logic [C_CNT_W-1:0] r_cnt;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_a, r_b, r_hi, r_lo;
    logic [WIDTH-1:0]   w_next_hi, w_next_lo;

    md_datapath #(
        .WIDTH     (WIDTH)
    ) u_datapath (
        .i_op      (r_op),
        .i_a       (r_a),
        .i_b       (r_b),
        .i_hi      (r_hi),
        .i_lo      (r_lo),
        .o_next_hi (w_next_hi),
        .o_next_lo (w_next_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= MD_NONE;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && !flush) begin
                        if (md_is_long(md_op)) begin
                            r_op    <= md_op;
                            r_a     <= rs_val;
                            r_b     <= rt_val;
                            r_cnt   <= md_is_div(md_op) ? C_DIV_CNT : C_MULT_CNT;
                            r_state <= ST_RUN;
                        end else if (md_op == MD_MTHI) begin
                            r_hi <= rs_val;
                        end else if (md_op == MD_MTLO) begin
                            r_lo <= rs_val;
                        end
                    end
                end
                ST_RUN: begin
                    // start is ignored while running; flush beats the commit edge
                    if (flush) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == C_ONE) begin
                        r_hi    <= w_next_hi;
                        r_lo    <= w_next_lo;
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - C_ONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (r_state == ST_RUN);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_md_unit_param.sv
// ============================================================================
// Module : tb_md_unit_param
// Brief  : Scoreboard bench for md_unit_param at default parameters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_md_unit_param;

    localparam int W        = 32;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic          clk;
    logic          reset;
    logic          start;
    logic [3:0]    md_op;
    logic          flush;
    logic [W-1:0]  rs_val;
    logic [W-1:0]  rt_val;
    logic          busy;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    md_unit_param #(
        .WIDTH    (W),
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .flush  (flush),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [63:0] hilo;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model written with native 64-bit integer arithmetic
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] h,
                                          input logic [31:0] l);
        longint ps, pu;
        int     ia, ib;
        ia = int'(a);
        ib = int'(b);
        ps = longint'(ia) * longint'(ib);
        pu = longint'({32'b0, a}) * longint'({32'b0, b});
        case (op)
            4'd1: return ps;
            4'd2: return pu;
            4'd3: begin
                if (b == 0) return {h, l};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                return {32'(ia % ib), 32'(ia / ib)};
            end
            4'd4: begin
                if (b == 0) return {h, l};
                return {a % b, a / b};
            end
            4'd5: return {h, l} + ps;
            4'd6: return {h, l} + pu;
            4'd7: return {h, l} - ps;
            4'd8: return {h, l} - pu;
            default: return {h, l};
        endcase
    endfunction

    // Called at a negedge; presents one start cycle and returns at the next negedge
    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        md_op  = op;
        rs_val = a;
        rt_val = b;
        @(negedge clk);
        start  = 1'b0;
        md_op  = 4'd0;
    endtask

    task automatic count_busy(inout int n);
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   n;
        e.hilo = model(op, a, b, m_hi, m_lo);
        e.lat  = (op == 4'd3 || op == 4'd4) ? DIV_LAT : MULT_LAT;
        sb.push_back(e);
        drive(op, a, b);
        n = 0;
        count_busy(n);
        e = sb.pop_front();
        chk({tag, "_lat"}, 64'(n), 64'(e.lat));
        chk({tag, "_hilo"}, {hi, lo}, e.hilo);
        {m_hi, m_lo} = e.hilo;
    endtask

    task automatic mt(input string tag, input logic [3:0] op, input logic [31:0] v);
        drive(op, v, 32'h0);
        if (op == 4'd9) m_hi = v;
        else            m_lo = v;
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_hilo"}, {hi, lo}, {m_hi, m_lo});
    endtask

    initial begin
        int n;
        reset  = 1'b1;
        start  = 1'b0;
        md_op  = 4'd0;
        flush  = 1'b0;
        rs_val = '0;
        rt_val = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_state", {31'b0, busy, hi, lo}, 65'h0);

        // Reset during a run
        mt("pre_hi", 4'd9, 32'h55);
        drive(4'd1, 32'd3, 32'd4);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        chk("rst_run", {31'b0, busy, hi, lo}, 65'h0);
        @(negedge clk);
        chk("rst_mf", {31'b0, busy, hi, lo}, 65'h0);

        run_op("mult_neg", 4'd1, 32'hFFFF_FFFF, 32'd2);
        chk("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2);
        chk("multu_const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        run_op("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        mt("mthi11", 4'd9, 32'h11);
        mt("mtlo22", 4'd10, 32'h22);
        run_op("divu_zero", 4'd4, 32'd7, 32'd0);
        chk("divu_zero_const", {hi, lo}, 64'h0000_0011_0000_0022);
        run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu", 4'd4, 32'd100, 32'd7);

        mt("mthi0", 4'd9, 32'h0);
        mt("mtloff", 4'd10, 32'hFFFF_FFFF);
        run_op("maddu", 4'd6, 32'd1, 32'd1);
        chk("maddu_const", {hi, lo}, 64'h0000_0001_0000_0000);
        run_op("msub", 4'd7, 32'd1, 32'd1);
        chk("msub_const", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
        run_op("madd", 4'd5, 32'hFFFF_FFFE, 32'd3);
        run_op("msubu", 4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Flush at busy cycle 4 of a divide
        drive(4'd3, 32'd100, 32'd3);
        repeat (3) @(negedge clk);
        chk("flush_pre_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_div", {31'b0, busy, hi, lo}, {1'b0, m_hi, m_lo});

        // Flush on the commit edge
        drive(4'd1, 32'd9, 32'd9);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_commit", {31'b0, busy, hi, lo}, {1'b0, m_hi, m_lo});

        // Starts issued while busy are ignored
        begin
            exp_t e;
            e.hilo = model(4'd1, 32'd3, 32'd4, m_hi, m_lo);
            e.lat  = MULT_LAT;
            sb.push_back(e);
            drive(4'd1, 32'd3, 32'd4);
            n = 1;
            @(negedge clk);
            drive(4'd1, 32'd5, 32'd6);
            n++;
            drive(4'd9, 32'hDEAD, 32'd0);
            n++;
            count_busy(n);
            e = sb.pop_front();
            chk("ign_lat", 64'(n), 64'(e.lat));
            chk("ign_hilo", {hi, lo}, e.hilo);
            {m_hi, m_lo} = e.hilo;
            @(negedge clk);
            chk("ign_after", {31'b0, busy, hi, lo}, {1'b0, m_hi, m_lo});
        end

        // Flush with start in IDLE, and reserved op codes
        flush = 1'b1;
        drive(4'd3, 32'd50, 32'd5);
        flush = 1'b0;
        chk("flush_idle", {31'b0, busy, hi, lo}, {1'b0, m_hi, m_lo});
        flush = 1'b1;
        drive(4'd9, 32'h77, 32'd0);
        flush = 1'b0;
        chk("flush_mthi", {31'b0, busy, hi, lo}, {1'b0, m_hi, m_lo});
        drive(4'd12, 32'd50, 32'd5);
        chk("op_reserved", {31'b0, busy, hi, lo}, {1'b0, m_hi, m_lo});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/md_unit_param.md
Name: md_unit_param

Overview:
- Parametrised multiply/divide unit with HI/LO registers for the EX stage of the 5-stage pipeline.
- Successor to the fixed-latency MD unit that drives `busy` into the ID-stage stall logic.
- Adds configurable operand width and per-class latency, multiply-accumulate ops, divide-by-zero handling, and a flush/abort input.
- Stall rule the pipeline applies to MD-class instructions in ID is `start | busy`; this block only guarantees the timing below.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_LAT, 5, cycles of `busy` for multiply and multiply-accumulate ops (must be ≥1).
- DIV_LAT, 10, cycles of `busy` for divide ops (must be ≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  op in `md_op` presented this cycle (EX stage).
- md_op  in  4  operation code (see Behaviour).
- flush  in  1  abort in-flight op; discard the `start` of this cycle.
- rs_val  in  WIDTH  operand A, already forwarded.
- rt_val  in  WIDTH  operand B, already forwarded.
- busy  out  1  long op in progress.
- hi  out  WIDTH  HI register (MFHI source).
- lo  out  WIDTH  LO register (MFLO source).

Behaviour:
- Interface: one clock `clk`; reset is synchronous and active-high, named `reset`.
- On reset: busy=0, hi=0, lo=0, counter=0, pending op cleared. Reset overrides flush and start in the same cycle.
- md_op codes:
  - 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU, 9 MTHI, 10 MTLO.
  - 11–15 are ignored as NONE.
- FSM states: IDLE and RUN.
- IDLE, start=1, flush=0, op in 1–8:
  - latch rs_val, rt_val and op.
  - load counter with MULT_LAT (ops 1,2,5–8) or DIV_LAT (ops 3,4).
  - go to RUN; busy rises at the next edge (first busy cycle = cycle after start).
- IDLE, start=1, op 9/10: hi (or lo) ← rs_val at the next edge; busy stays 0; single cycle.
- RUN: counter decrements each cycle. At the edge where the counter reaches 0:
  - commit the result to hi/lo.
  - busy falls; go to IDLE.
  - New hi/lo is visible in the same cycle busy reads 0.
  - Total: busy high exactly LAT cycles.
- start while busy=1 (any op, including MTHI/MTLO): ignored. The pipeline must not issue this; the bench checks that it is ignored.
- flush=1 in RUN: return to IDLE next edge, busy=0, hi/lo unchanged.
- flush=1 with start in IDLE: start discarded.
- flush on the commit edge: flush wins, no commit.
- Arithmetic, all results computed from latched operands at 2·WIDTH:
  - MULT: {hi,lo} = signed A × signed B.
  - MULTU: {hi,lo} = unsigned A × unsigned B.
  - MADD / MSUB: {hi,lo} = {hi,lo} ± signed product, using the hi/lo value at commit time, wrap modulo 2^(2·WIDTH).
  - MADDU / MSUBU: same as MADD / MSUB with an unsigned product.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (B==0): op still occupies DIV_LAT busy cycles; hi/lo unchanged at commit.
- Signed overflow (min_int / −1): lo = min_int, hi = 0.
- hi/lo are plain registers with no bypass of an in-flight result.

Decomposition:
- Shared package `md_pkg`:
  - md_op localparams (MD_NONE … MD_MTLO).
  - state encoding IDLE/RUN.
  - helper for counter width, clog2(max(MULT_LAT,DIV_LAT)+1).
- One natural sub-module: `md_datapath`. Combinational product/quotient/remainder/accumulate from latched operands, op and current hi/lo. Yields next_hi/next_lo.
- The top holds the FSM, counter and registers.

Test Plan:
- Reset mid-RUN: MULT 3×4, assert reset at busy cycle 2 → next cycle busy=0, hi=0, lo=0; later MFHI/MFLO read 0.
- MULT timing (defaults): MULT rs=0xFFFFFFFF (−1), rt=2 → busy high exactly 5 cycles starting the cycle after start; at busy fall hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- Signed division: DIV rs=−7 (0xFFFFFFF9), rt=2 → 10 busy cycles, then lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1).
- Divide edge cases:
  - DIVU 7/0 with hi=0x11, lo=0x22 preset via MTHI/MTLO → 10 busy cycles, then hi=0x11, lo=0x22 unchanged.
  - DIV 0x80000000/−1 → lo=0x80000000, hi=0.
- Accumulate and wrap: MTHI 0, MTLO 0xFFFFFFFF (busy stays 0, values visible next cycle), then MADDU 1×1 → hi=1, lo=0. Then MSUB 1×1 → hi=0, lo=0xFFFFFFFF.
- Flush and ignored start:
  - DIV 100/3, flush at busy cycle 4 → busy=0 next cycle, hi/lo unchanged.
  - MULT issued during busy → ignored; final result is from the first op only.
  - flush together with start in IDLE → no busy.
